mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer that shares one single-port unified memory between the pipeline's instruction-fetch port and its load/store port. It sits between the fetch/decode stages of the pipelined CPU and the memory model. It runs the memory request/grant/response handshake with one access outstanding, and returns per-port acknowledge and stall signals. The pipeline uses these stalls as structural-hazard inputs.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- MAX_DATA_RUN, 4, consecutive data grants allowed while a fetch is pending; range 1..15
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched instruction; valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for the fetch port
- if_stall  out  1  combinational, equal to if_req & ~if_ack
- d_req  in  1  data request; held with all d_* inputs until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_wstrb  in  DATA_WIDTH/8  store byte enables
- d_rdata  out  DATA_WIDTH  load data; valid while d_ack=1 for loads
- d_ack  out  1  one-cycle completion pulse for the data port
- d_stall  out  1  combinational, equal to d_req & ~d_ack
- mem_req  out  1  memory request; held until mem_gnt
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered request fields; stable while mem_req=1
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  access complete; mem_rdata valid this cycle
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- The FSM has three states: IDLE, REQ and RESP.
- **IDLE**:
  - Evaluate the requests that are not masked.
  - A port is masked in the cycle its ack is high.
  - If any unmasked request is present, pick a winner and register mem_req=1 plus the winner's fields.
  - Latch the source (IF or D), then go to REQ.
  - If no request is present, stay in IDLE with mem_req=0.
- **Arbitration**:
  - d wins by default.
  - if wins when only if_req is present.
  - if also wins when if_req=1 and run_cnt >= MAX_DATA_RUN.
- **run_cnt (4 bits)**:
  - Increments on each d grant made while if_req=1, saturating at 15.
  - Clears to 0 on each if grant.
  - Clears when a d grant is made with if_req=0.
- **Fetch grant fields**: a fetch is issued with mem_we=0 and mem_wstrb=0.
- **REQ**:
  - mem_req and all fields are held constant.
  - On mem_gnt=1, go to RESP; mem_req drops to 0 on that edge.
- **RESP**:
  - Wait for mem_rvalid.
  - On mem_rvalid=1, register the result to the winner's port.
  - For if, or for a d load, load mem_rdata into the port's rdata register.
  - For a d store, d_rdata keeps its previous value.
  - Assert the winner's ack for one cycle, then return to IDLE.
- **Ignored inputs**: mem_rvalid outside RESP and mem_gnt outside REQ are ignored.
- **Request changes mid-access**:
  - Request inputs are never re-sampled during REQ or RESP.
  - If a requester drops req mid-access, the access still completes and is still acked.
- **Reset** (reset=0, at any time, including mid-access):
  - Immediately, without waiting for a clock edge: state IDLE, run_cnt=0.
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb go to 0.
  - if_ack, d_ack, if_rdata and d_rdata go to 0.
  - The in-flight access is abandoned; no ack is issued for it.

## Timing
- Cycle 0: req is high in IDLE.
- Cycle 1: mem_req=1.
- Grant: mem_gnt is seen in cycle g >= 1.
- Response: mem_rvalid is seen in cycle r >= g+1.
- Ack: ack=1 in cycle r+1, when the FSM is already in IDLE.
- Minimum request-to-ack latency is 3 cycles (g=1, r=2).
- Back-to-back: in the ack cycle, the other port's pending request can be granted, giving mem_req=1 in the cycle after the ack. The acked port's next request is considered from cycle r+2.
- Simultaneous if_req and d_req in IDLE are resolved by the arbitration rule; the loser's stall stays high throughout.
- if_stall and d_stall are purely combinational and must have no flop in the path.

## Test plan
1. **Reset values**: reset=0 -> all outputs 0; after release with no requests, mem_req stays 0 for 10 cycles.
2. **Single fetch**:
   - Stimulus: if_addr=0x40; mem_gnt in cycle 1; mem_rvalid with 0x00500093 in cycle 2.
   - Required: mem_addr=0x40 and mem_we=0 in cycle 1; if_ack=1 and if_rdata=0x00500093 in cycle 3; if_stall=1 in cycles 0-2 and 0 in cycle 3.
3. **Store**:
   - Stimulus: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=4'b0011; mem_gnt delayed to cycle 4; rvalid in cycle 7.
   - Required: fields stable in cycles 1-4; d_ack=1 in cycle 8; d_rdata unchanged.
4. **Simultaneous requests**:
   - Stimulus: if_req and d_req both held; memory answers with g=1, r=2.
   - Required: d granted first; if granted in the d_ack cycle, so mem_req=1 in the following cycle.
5. **Fetch fairness**:
   - Stimulus: d_req held continuously with MAX_DATA_RUN=4 and if_req=1.
   - Required: grant order d,d,d,d,if,d,...; run_cnt=0 after the if grant.
6. **Reset mid-access**:
   - Stimulus: assert reset=0 in RESP, then release; then issue a fresh fetch.
   - Required: no ack for the abandoned access; a late mem_rvalid is ignored; the fresh fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch port (if_*)
//   and the load/store port (d_*). One access is outstanding at a time; the
//   memory side uses a req/gnt request phase followed by an rvalid response.
//   The data port wins by default, but once it has taken MAX_DATA_RUN grants
//   in a row while a fetch was waiting, the fetch is served next.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   if_req/if_addr    fetch request (held until if_ack)
//   if_rdata/if_ack   fetch result and one-cycle completion pulse
//   if_stall          if_req & ~if_ack (combinational)
//   d_req/d_we/d_addr/d_wdata/d_wstrb  load/store request (held until d_ack)
//   d_rdata/d_ack     load result and one-cycle completion pulse
//   d_stall           d_req & ~d_ack (combinational)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  registered memory request
//   mem_gnt           memory accepted the request
//   mem_rvalid/mem_rdata  access complete, read data
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ack,
  output logic                    if_stall,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ack,
  output logic                    d_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    src_d_q, src_d_d;      // 1: data port owns the access
  logic [3:0]              run_cnt_q, run_cnt_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]       mem_wstrb_q, mem_wstrb_d;
  logic                    if_ack_q, if_ack_d;
  logic                    d_ack_q, d_ack_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;

  logic                    if_cand;
  logic                    d_cand;
  logic                    pick_if;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      src_d_q     <= 1'b0;
      run_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_d_q     <= src_d_d;
      run_cnt_q   <= run_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d_d     = src_d_q;
    run_cnt_d   = run_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    // A port's request is still high in its own ack cycle but is already
    // satisfied, so it must not start a second access.
    if_cand = if_req & ~if_ack_q;
    d_cand  = d_req & ~d_ack_q;
    pick_if = if_cand & (~d_cand | (run_cnt_q >= MAX_RUN));

    unique case (state_q)
      S_IDLE: begin
        if (if_cand || d_cand) begin
          state_d   = S_REQ;
          mem_req_d = 1'b1;
          if (pick_if) begin
            src_d_d     = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            run_cnt_d   = '0;
          end else begin
            src_d_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wstrb_d = d_wstrb;
            // Count only data grants that made a fetch wait.
            if (!if_req) begin
              run_cnt_d = '0;
            end else if (run_cnt_q != 4'hF) begin
              run_cnt_d = run_cnt_q + 4'd1;
            end
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          if (src_d_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// requesters and memory, all checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXR = 4;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_stall;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MAX_DATA_RUN(MAXR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .if_stall  (if_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One access at most is outstanding; it is either waiting for the grant
  // or, once granted, waiting for the response.
  bit            m_busy;
  bit            m_granted;
  bit            m_is_d;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  int            m_run;
  bit            exp_mem_req;
  bit            exp_if_ack;
  bit            exp_d_ack;
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_d_rdata;

  task automatic model_reset();
    m_busy       = 0;
    m_granted    = 0;
    m_is_d       = 0;
    m_run        = 0;
    exp_mem_req  = 0;
    exp_if_ack   = 0;
    exp_d_ack    = 0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
  endtask

  // Advance the model across the coming rising edge using this cycle's inputs.
  task automatic model_step();
    bit nx_if_ack = 0;
    bit nx_d_ack  = 0;
    bit if_live;
    bit d_live;
    if (!m_busy) begin
      if_live = if_req && !exp_if_ack;
      d_live  = d_req && !exp_d_ack;
      if (if_live || d_live) begin
        m_busy    = 1;
        m_granted = 0;
        if (if_live && (!d_live || m_run >= MAXR)) begin
          m_is_d  = 0;
          m_we    = 0;
          m_addr  = if_addr;
          m_wdata = '0;
          m_wstrb = '0;
          m_run   = 0;
        end else begin
          m_is_d  = 1;
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          m_wstrb = d_wstrb;
          m_run   = if_req ? ((m_run < 15) ? m_run + 1 : 15) : 0;
        end
      end
    end else if (!m_granted) begin
      if (mem_gnt) m_granted = 1;
    end else if (mem_rvalid) begin
      m_busy = 0;
      if (m_is_d) begin
        nx_d_ack = 1;
        if (!m_we) exp_d_rdata = mem_rdata;
      end else begin
        nx_if_ack    = 1;
        exp_if_rdata = mem_rdata;
      end
    end
    exp_if_ack  = nx_if_ack;
    exp_d_ack   = nx_d_ack;
    exp_mem_req = m_busy && !m_granted;
  endtask

  // Called #1 after this cycle's inputs were driven at the falling edge.
  task automatic tick();
    if (!reset) model_reset();
    check_eq("mem_req", mem_req, exp_mem_req);
    check_eq("if_ack", if_ack, exp_if_ack);
    check_eq("d_ack", d_ack, exp_d_ack);
    check_eq("if_rdata", if_rdata, exp_if_rdata);
    check_eq("d_rdata", d_rdata, exp_d_rdata);
    check_eq("if_stall", if_stall, if_req & ~exp_if_ack);
    check_eq("d_stall", d_stall, d_req & ~exp_d_ack);
    if (exp_mem_req) begin
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("mem_we", mem_we, m_we);
      check_eq("mem_wstrb", mem_wstrb, m_wstrb);
      if (m_is_d) check_eq("mem_wdata", mem_wdata, m_wdata);
    end
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req     = 0;
    if_addr    = '0;
    d_req      = 0;
    d_we       = 0;
    d_addr     = '0;
    d_wdata    = '0;
    d_wstrb    = '0;
    mem_gnt    = 0;
    mem_rvalid = 0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    #1;
    tick();
    reset = 1;
    #1;
    tick();
  endtask

  bit            pend;
  bit            win_if[10];
  int            n_win;
  logic [DW-1:0] rnd;

  initial begin
    reset = 0;
    clear_inputs();
    model_reset();
    @(negedge clk);

    // ---- reset values ----
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_mem_wstrb", mem_wstrb, 0);
    check_eq("rst_if_ack", if_ack, 0);
    check_eq("rst_d_ack", d_ack, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    tick();
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("idle_mem_req", mem_req, 0);
      tick();
    end

    // ---- single fetch ----
    do_reset();
    if_req = 1; if_addr = 32'h40;
    #1; check_eq("f_stall_c0", if_stall, 1); tick();
    mem_gnt = 1;
    #1;
    check_eq("f_mem_req_c1", mem_req, 1);
    check_eq("f_mem_addr_c1", mem_addr, 32'h40);
    check_eq("f_mem_we_c1", mem_we, 0);
    check_eq("f_stall_c1", if_stall, 1);
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    #1; check_eq("f_stall_c2", if_stall, 1); tick();
    mem_rvalid = 0; mem_rdata = '0;
    #1;
    check_eq("f_ack_c3", if_ack, 1);
    check_eq("f_rdata_c3", if_rdata, 32'h0050_0093);
    check_eq("f_stall_c3", if_stall, 0);
    tick();
    if_req = 0;
    #1; check_eq("f_no_regrant", mem_req, 0); tick();

    // ---- store with delayed grant ----
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    #1; tick();
    for (int c = 1; c <= 4; c++) begin
      mem_gnt = (c == 4);
      #1;
      check_eq("s_mem_req", mem_req, 1);
      check_eq("s_mem_we", mem_we, 1);
      check_eq("s_mem_addr", mem_addr, 32'h100);
      check_eq("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check_eq("s_mem_wstrb", mem_wstrb, 4'b0011);
      tick();
    end
    mem_gnt = 0;
    #1; tick();
    #1; tick();
    mem_rvalid = 1; mem_rdata = 32'h55AA_55AA;
    #1; check_eq("s_ack_c7", d_ack, 0); tick();
    mem_rvalid = 0;
    #1;
    check_eq("s_ack_c8", d_ack, 1);
    check_eq("s_rdata_kept", d_rdata, 0);
    tick();
    d_req = 0;
    #1; tick();

    // ---- simultaneous requests ----
    do_reset();
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    #1; tick();
    mem_gnt = 1;
    #1;
    check_eq("sim_first_addr", mem_addr, 32'h200);
    check_eq("sim_if_stall", if_stall, 1);
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
    #1; tick();
    mem_rvalid = 0;
    #1;
    check_eq("sim_d_ack", d_ack, 1);
    check_eq("sim_d_rdata", d_rdata, 32'hCAFE_0001);
    check_eq("sim_if_stall_ack", if_stall, 1);
    tick();
    d_req = 0; mem_gnt = 1;
    #1;
    check_eq("sim_if_req", mem_req, 1);
    check_eq("sim_if_addr", mem_addr, 32'h300);
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0011;
    #1; tick();
    mem_rvalid = 0;
    #1;
    check_eq("sim_if_ack", if_ack, 1);
    check_eq("sim_if_rdata", if_rdata, 32'h11);
    tick();
    if_req = 0;
    #1; tick();

    // ---- fetch fairness ----
    // The fetch withdraws during each d_ack cycle so the data port can take
    // consecutive grants; the run limit must then force the fetch through.
    do_reset();
    pend = 0; n_win = 0;
    d_we = 0; d_addr = 32'h2000; if_addr = 32'h1000;
    for (int c = 0; c < 60; c++) begin
      d_req = 1;
      if_req = ~d_ack;
      mem_rvalid = pend;
      mem_rdata = $urandom;
      mem_gnt = mem_req;
      pend = mem_req;
      if (mem_req && n_win < 10) begin
        win_if[n_win] = (mem_addr == 32'h1000);
        n_win++;
      end
      #1; tick();
    end
    check_eq("fair_count", n_win, 10);
    for (int i = 0; i < 10; i++) check_eq($sformatf("fair_grant%0d", i), win_if[i], (i == 4 || i == 9));

    // ---- reset mid-access ----
    do_reset();
    if_req = 1; if_addr = 32'h80;
    #1; tick();
    mem_gnt = 1;
    #1; tick();
    mem_gnt = 0;
    #1; tick();
    reset = 0; if_req = 0;
    #1;
    check_eq("ra_mem_req", mem_req, 0);
    check_eq("ra_mem_addr", mem_addr, 0);
    tick();
    reset = 1;
    #1; tick();
    mem_rvalid = 1; mem_rdata = 32'hBADB_AD00;
    #1; tick();
    mem_rvalid = 0;
    #1;
    check_eq("ra_no_ack", if_ack, 0);
    check_eq("ra_no_rdata", if_rdata, 0);
    if_req = 1; if_addr = 32'h84;
    #1; tick();
    mem_gnt = 1;
    #1; check_eq("ra_fresh_addr", mem_addr, 32'h84); tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    #1; tick();
    mem_rvalid = 0;
    #1;
    check_eq("ra_fresh_ack", if_ack, 1);
    check_eq("ra_fresh_rdata", if_rdata, 32'h13);
    tick();
    if_req = 0;
    #1; tick();

    // ---- randomized traffic ----
    do_reset();
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_req && if_ack) begin
        if_req = $urandom_range(0, 1);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (!if_req) begin
        if ($urandom_range(0, 3) == 0) begin
          if_req = 1;
          if_addr = $urandom & 32'hFFFF_FFFC;
        end
      end else if ($urandom_range(0, 31) == 0) begin
        if_req = 0;
      end
      if ((d_req && d_ack) || !d_req) begin
        d_req = (d_req && d_ack) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
        d_we = $urandom_range(0, 1);
        d_addr = $urandom;
        d_wdata = $urandom;
        rnd = $urandom;
        d_wstrb = rnd[SW-1:0];
      end else if ($urandom_range(0, 31) == 0) begin
        d_req = 0;
      end
      mem_rdata = $urandom;
      mem_rvalid = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      if (mem_rvalid) pend = 0;
      mem_gnt = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      if (mem_req && mem_gnt) pend = 1;
      reset = ($urandom_range(0, 299) != 0);
      if (!reset) begin
        pend = 0;
        if_req = 0;
        d_req = 0;
      end
      #1; tick();
      reset = 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
